// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the RV32 NOP encoding and the stage-register state enum.
package pipeline_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipeline_stage_reg.sv
// Handshaked inter-stage register carrying pc/instr/data/ctrl with flush, NOP injection and a
// saturating stall counter. Define PIPELINE_STAGE_REG_SKID_EN for a second (skid) entry and registered in_ready.
module pipeline_stage_reg
   import pipeline_pkg::*;
#(
   parameter int unsigned PC_W        = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned CTRL_W      = 8,
   parameter logic [31:0] NOP_INSTR   = RV_NOP,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PC_W-1:0]        in_pc,
   input  logic [31:0]            in_instr,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [31:0]            out_instr,
   output logic [DATA_W-1:0]      out_data,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   pipe_state_e             state_q, state_d;
   logic [PC_W-1:0]         pc_q, pc_d;
   logic [31:0]             instr_q, instr_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
   logic [STALL_CNT_W-1:0]  stall_q, stall_d;
`ifdef PIPELINE_STAGE_REG_SKID_EN
   logic [PC_W-1:0]         skid_pc_q, skid_pc_d;
   logic [31:0]             skid_instr_q, skid_instr_d;
   logic [DATA_W-1:0]       skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]       skid_ctrl_q, skid_ctrl_d;
`endif
   logic                    accept;
   logic                    consume;

   assign out_valid = (state_q != EMPTY);
`ifdef PIPELINE_STAGE_REG_SKID_EN
   assign in_ready  = (state_q != SKID);
`else
   assign in_ready  = !out_valid || out_ready;
`endif
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   assign out_pc       = pc_q;
   assign out_instr    = instr_q;
   assign out_data     = data_q;
   assign out_ctrl     = ctrl_q;
   assign stall_cycles = stall_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      stall_d = stall_q;
`ifdef PIPELINE_STAGE_REG_SKID_EN
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
`endif

      if (out_valid && !out_ready && !flush && (stall_q != '1))
         stall_d = stall_q + STALL_ONE;

      if (flush) begin
         state_d = EMPTY;
         instr_d = NOP_INSTR;
         ctrl_d  = '0;
`ifdef PIPELINE_STAGE_REG_SKID_EN
         skid_instr_d = NOP_INSTR;
         skid_ctrl_d  = '0;
`endif
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  pc_d    = in_pc;
                  instr_d = in_instr;
                  data_d  = in_data;
                  ctrl_d  = in_ctrl;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (accept && consume) begin
                  pc_d    = in_pc;
                  instr_d = in_instr;
                  data_d  = in_data;
                  ctrl_d  = in_ctrl;
               end else if (consume) begin
                  // An emptied stage must present a harmless NOP to downstream.
                  instr_d = NOP_INSTR;
                  ctrl_d  = '0;
                  state_d = EMPTY;
               end
`ifdef PIPELINE_STAGE_REG_SKID_EN
               else if (accept) begin
                  skid_pc_d    = in_pc;
                  skid_instr_d = in_instr;
                  skid_data_d  = in_data;
                  skid_ctrl_d  = in_ctrl;
                  state_d      = SKID;
               end
`endif
            end
`ifdef PIPELINE_STAGE_REG_SKID_EN
            SKID: begin
               if (consume) begin
                  pc_d         = skid_pc_q;
                  instr_d      = skid_instr_q;
                  data_d       = skid_data_q;
                  ctrl_d       = skid_ctrl_q;
                  skid_instr_d = NOP_INSTR;
                  skid_ctrl_d  = '0;
                  state_d      = FULL;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         pc_q    <= '0;
         instr_q <= NOP_INSTR;
         data_q  <= '0;
         ctrl_q  <= '0;
         stall_q <= '0;
`ifdef PIPELINE_STAGE_REG_SKID_EN
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
`endif
      end else begin
         // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         stall_q <= stall_d;
`ifdef PIPELINE_STAGE_REG_SKID_EN
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: a queue-based occupancy model checked every cycle plus literal spot checks.
// Honours PIPELINE_STAGE_REG_SKID_EN the same way the design does.
module tb_pipeline_stage_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] data;
      logic [7:0]  ctrl;
   } beat_t;

   logic        clock;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_instr, in_data;
   logic [7:0]  in_ctrl;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_instr, out_data;
   logic [7:0]  out_ctrl;
   logic [15:0] stall_cycles;

   logic        s_in_ready, s_out_valid;
   logic [31:0] s_out_pc, s_out_instr, s_out_data;
   logic [7:0]  s_out_ctrl;
   logic [3:0]  s_stall;

   pipeline_stage_reg dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_ctrl(in_ctrl),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cycles(stall_cycles)
   );

   pipeline_stage_reg #(.STALL_CNT_W(4)) dut_sat (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_ctrl(in_ctrl),
      .flush(flush),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_pc(s_out_pc), .out_instr(s_out_instr), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
      .stall_cycles(s_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         passed++;
   endtask

   // Model: the stage is a FIFO of held beats with capacity 1 (2 with the skid entry).
   beat_t q[$];
   int    m_stall = 0;
   int    m_sat   = 0;

   function automatic logic exp_in_ready();
`ifdef PIPELINE_STAGE_REG_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || out_ready;
`endif
   endfunction

   always @(posedge clock or negedge reset_n) begin
      logic rdy;
      logic cons;
      logic acc;
      beat_t b;
      if (!reset_n) begin
         q.delete();
         m_stall = 0;
         m_sat   = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         rdy  = exp_in_ready();
         cons = (q.size() != 0) && out_ready;
         acc  = in_valid && rdy;
         if ((q.size() != 0) && !out_ready) begin
            if (m_stall < 65535) m_stall++;
            if (m_sat < 15) m_sat++;
         end
         if (cons) void'(q.pop_front());
         if (acc) begin
            b.pc = in_pc; b.instr = in_instr; b.data = in_data; b.ctrl = in_ctrl;
            q.push_back(b);
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         check("in_ready", in_ready, exp_in_ready());
         check("out_valid", out_valid, q.size() != 0);
         check("stall_cycles", stall_cycles, m_stall);
         check("stall_sat", s_stall, m_sat);
         if (q.size() != 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
            check("out_data", out_data, q[0].data);
            check("out_ctrl", out_ctrl, q[0].ctrl);
         end else begin
            check("idle_instr", out_instr, NOP);
            check("idle_ctrl", out_ctrl, 8'h00);
         end
      end
   end

   function automatic beat_t mk(input int i);
      beat_t b;
      b.pc    = 32'(i * 4);
      b.instr = 32'h00A0_0000 | 32'(i);
      b.data  = 32'hD000_0000 + 32'(i);
      b.ctrl  = 8'h80 | 8'(i);
      return b;
   endfunction

   // Drive one cycle of inputs; acc reports whether the beat was taken (for stimulus pacing only).
   task automatic step(input logic v, input beat_t b, input logic ordy, input logic fl, output logic acc);
      in_valid  = v;
      in_pc     = b.pc;
      in_instr  = b.instr;
      in_data   = b.data;
      in_ctrl   = b.ctrl;
      out_ready = ordy;
      flush     = fl;
      @(negedge clock);
      acc = in_valid && in_ready && !fl;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic acc;
      int   idx;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      in_data   = '0;
      in_ctrl   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_instr", out_instr, 32'h0000_0013);
      check("rst_out_ctrl", out_ctrl, 8'h00);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_stall", stall_cycles, 16'd0);
      check("rst_in_ready", in_ready, 1'b1);
      reset_n = 1'b1;

      // Streaming: eight back-to-back beats, each visible one edge after acceptance.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, mk(k), 1'b1, 1'b0, acc);
         check("stream_acc", acc, 1'b1);
         check("stream_pc", out_pc, 32'(k * 4));
         check("stream_valid", out_valid, 1'b1);
      end
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      check("stream_end_valid", out_valid, 1'b0);
      check("stream_end_instr", out_instr, 32'h0000_0013);

      // Reset mid-stream takes effect without a clock edge.
      step(1'b1, mk(9), 1'b1, 1'b0, acc);
      check("mid_pre_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_instr", out_instr, 32'h0000_0013);
      check("mid_rst_ctrl", out_ctrl, 8'h00);
      check("mid_rst_stall", stall_cycles, 16'd0);
      #1;
      reset_n = 1'b1;

      // Backpressure: one accept, then five stalled cycles with upstream still offering.
      idx = 0;
      step(1'b1, mk(idx), 1'b1, 1'b0, acc);
      if (acc) idx++;
      repeat (5) begin
         step(1'b1, mk(idx), 1'b0, 1'b0, acc);
         if (acc) idx++;
      end
      check("bp_stall", stall_cycles, 16'd5);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_head_pc", out_pc, 32'h0);
`ifdef PIPELINE_STAGE_REG_SKID_EN
      check("bp_held", idx, 2);
`else
      check("bp_held", idx, 1);
`endif
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
`ifdef PIPELINE_STAGE_REG_SKID_EN
      check("bp_drain_valid", out_valid, 1'b1);
      check("bp_drain_pc", out_pc, 32'h4);
`else
      check("bp_drain_valid", out_valid, 1'b0);
`endif
      repeat (2) step(1'b0, mk(0), 1'b1, 1'b0, acc);
      check("bp_empty", out_valid, 1'b0);

      // Flush while full (SKID in the skid build) with a beat offered in the same cycle.
      step(1'b1, mk(20), 1'b0, 1'b0, acc);
      step(1'b1, mk(21), 1'b0, 1'b0, acc);
`ifdef PIPELINE_STAGE_REG_SKID_EN
      check("fl_pre_in_ready", in_ready, 1'b0);
`endif
      step(1'b1, mk(22), 1'b1, 1'b1, acc);
      check("fl_valid", out_valid, 1'b0);
      check("fl_ctrl", out_ctrl, 8'h00);
      check("fl_instr", out_instr, 32'h0000_0013);
      check("fl_stall_kept", stall_cycles, 16'd6);
      check("fl_in_ready", in_ready, 1'b1);
      step(1'b0, mk(0), 1'b1, 1'b0, acc);
      check("fl_not_emitted", out_valid, 1'b0);

`ifndef PIPELINE_STAGE_REG_SKID_EN
      // Without the skid entry in_ready follows out_ready combinationally.
      step(1'b1, mk(30), 1'b1, 1'b0, acc);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("comb_rdy_lo", in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      check("comb_rdy_hi", in_ready, 1'b1);
`endif

      // Saturation: twenty stalls push the 4-bit counter to all-ones where it stays.
      step(1'b1, mk(31), 1'b1, 1'b0, acc);
      check("sat_pre_valid", out_valid, 1'b1);
      repeat (20) step(1'b0, mk(0), 1'b0, 1'b0, acc);
      check("sat_value", s_stall, 4'hF);
      check("sat_wide", stall_cycles, 16'd26);
      repeat (2) step(1'b0, mk(0), 1'b0, 1'b0, acc);
      check("sat_hold", s_stall, 4'hF);
      check("sat_wide_more", stall_cycles, 16'd28);
      check("sat_held_pc", out_pc, 32'(31 * 4));
      repeat (2) step(1'b0, mk(0), 1'b1, 1'b0, acc);
      check("final_empty", out_valid, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_stage_reg.md
# pipeline_stage_reg

Parametrised, handshaked pipeline register for the staged RV32 core; one instance goes between every pair of adjacent stages (fetch/decode, execute/memory, and so on). It carries PC, instruction, a data word and a control bundle with a valid/ready handshake. It also provides flush with NOP injection, an optional skid entry that registers upstream ready, and a saturating stall counter for performance analysis.

## Interface
- `PC_W`, default 32: program-counter width.
- `DATA_W`, default 32: payload word width (ALU result, store data, etc.).
- `CTRL_W`, default 8: control bundle width (reg_wr, mem_wr, waddr, size, ...). All-zero means "no side effect".
- `NOP_INSTR`, default 32'h0000_0013: instruction word placed in an emptied or flushed stage.
- `STALL_CNT_W`, default 16: width of the stall counter.
- `clock`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream holds a valid beat.
- `in_ready`, output, 1: stage accepts the beat this cycle.
- `in_pc`, input, PC_W: upstream PC.
- `in_instr`, input, 32: upstream instruction.
- `in_data`, input, DATA_W: upstream payload.
- `in_ctrl`, input, CTRL_W: upstream control bundle.
- `flush`, input, 1: kill all held beats, for example on a branch redirect.
- `out_valid`, output, 1: downstream beat valid.
- `out_ready`, input, 1: downstream consumes the beat.
- `out_pc`, output, PC_W: registered PC.
- `out_instr`, output, 32: registered instruction.
- `out_data`, output, DATA_W: registered payload.
- `out_ctrl`, output, CTRL_W: registered control bundle.
- `stall_cycles`, output, STALL_CNT_W: number of cycles with out_valid=1 and out_ready=0; saturates at all-ones.

## Operation
- A beat is accepted on a clock edge where in_valid=1 and in_ready=1. A beat is consumed on a clock edge where out_valid=1 and out_ready=1.
- Reset (reset_n=0, applied asynchronously) sets:
  - out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_data=0, out_ctrl=0;
  - the skid entry to invalid;
  - stall_cycles=0;
  - the state to EMPTY.
- Whenever out_valid=0, out_ctrl is forced to 0 and out_instr is forced to NOP_INSTR, so downstream never sees a write from an invalid beat.
- Flush has priority over everything else. On the flush edge the stage:
  - invalidates the main and skid entries;
  - loads NOP_INSTR and ctrl 0;
  - discards any beat presented for acceptance in the same cycle;
  - moves to EMPTY.
  The stall counter is not cleared by flush.
- State machine (skid build):
  - EMPTY: on accept, go to FULL.
  - FULL: accept with consume, stay FULL and load the new beat. Consume only, go to EMPTY. Accept only, go to SKID; the new beat goes into the skid entry.
  - SKID: in_ready=0. On consume, the skid entry moves to main and the state goes to FULL.
- Upstream pc/instr/data/ctrl are captured only on accept. Held values stay stable while out_valid=1 and out_ready=0.
- stall_cycles increments by 1 on every edge with out_valid=1, out_ready=0 and flush=0. Once it reaches 2^STALL_CNT_W−1 it holds that value.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N and is valid for consumption from cycle N+1.
- Throughput: 1 beat per cycle while out_ready=1.
- Skid build: in_ready is a pure register output (in_ready = state≠SKID), with no combinational path from out_ready.
- Without skid: in_ready = !out_valid | out_ready, which is combinational from out_ready.
- reset_n assertion takes effect immediately. Deassertion is synchronised externally, and the first accept can happen at the first edge after deassertion.

## Configuration
- `PIPELINE_STAGE_REG_SKID_EN` defined: the skid entry and the SKID state are built, and in_ready is registered. Two beats can be held.
- Not defined: there is no skid entry and only the EMPTY/FULL states exist. in_ready is combinational as given under Timing. At most one beat is held.

## Structure
- Shared package `pipeline_pkg` holds:
  - the constant `RV_NOP` (32'h0000_0013), used as the NOP_INSTR default;
  - the state enum `pipe_state_e` {EMPTY, FULL, SKID}.
- No sub-module: the stall counter and the skid entry stay inline in this module.

## Test plan
- Reset mid-stream: assert reset_n=0 with out_valid=1 -> immediately out_valid=0, out_instr=32'h13, out_ctrl=0, stall_cycles=0.
- Streaming: 8 back-to-back beats with pc 0x0,0x4,…,0x1C and out_ready=1 -> the same sequence appears on out_pc, one cycle later, one beat per cycle.
- Backpressure (skid build): hold out_ready=0 for 5 cycles while in_valid=1 -> 2 beats held, in_ready=0 from the cycle after the second accept, stall_cycles=5, then both beats drain in order with no loss.
- Flush with simultaneous accept: in SKID state, flush=1 with in_valid=1 -> next cycle out_valid=0, state EMPTY, the incoming beat is not emitted, and out_ctrl=0.
- Counter saturation: STALL_CNT_W=4 and 20 stall cycles -> stall_cycles=4'hF and it holds.
- Macro off: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 in the same cycle.
